// File: rtl/serial_pkg.sv
// Shared definitions for the serial register write/read path: FSM states,
// frame constants and register address map.
// No logic; constants only.
package serial_pkg;

    // Receive-frame decoder states, one per expected byte of the frame.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // SYNC, ADDR, DHI, DLO, CSUM.
    localparam int FRAME_LEN = 5;

    // Register address map, shared with the read mux.
    localparam logic [7:0] ADDR_DATA0 = 8'd0;
    localparam logic [7:0] ADDR_DATA1 = 8'd1;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer: counts idle cycles and flags when the gap limit is hit.
// Latency: expired is combinational from the count, clear and enable inputs.
// Backpressure: none; clear always wins over expiry in the same cycle.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : zero the count (accepted byte, or decoder idle)
//   enable      : count while a partial frame is open
//   expired     : high for the cycle in which the count sits at TIMEOUT_CYCLES-1
//                 with enable set and no clear
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Saturate at LAST so a stalled count can never wrap back into range.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/serial_reg_writer.sv
// UART RX frame decoder: SYNC,ADDR,DHI,DLO,CSUM -> 16-bit register write.
// Latency: 1 clk from the CSUM byte to data/wr_addr update and status pulse.
// Backpressure: none; one byte accepted per rx_valid cycle, back-to-back legal.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   rx_data/rx_valid : byte stream from the UART receiver
//   data_0, data_1   : registers at address 0 and 1
//   wr_addr          : address of the last committed write
//   wr_strobe        : one-cycle pulse per commit
//   csum_err         : one-cycle pulse on checksum mismatch
//   addr_err         : one-cycle pulse on good frame with unmapped address
//   timeout_err      : one-cycle pulse when a partial frame is abandoned
module serial_reg_writer
    import serial_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] data_0,
    output logic [15:0] data_1,
    output logic [7:0]  wr_addr,
    output logic        wr_strobe,
    output logic        csum_err,
    output logic        addr_err,
    output logic        timeout_err
);

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_addr;
    logic [7:0]  r_dhi;
    logic [7:0]  r_dlo;
    logic [7:0]  r_csum;

    logic [15:0] r_data_0;
    logic [15:0] r_data_1;
    logic [7:0]  r_wr_addr;
    logic        r_wr_strobe;
    logic        r_csum_err;
    logic        r_addr_err;
    logic        r_timeout_err;

    logic        w_commit;
    logic        w_csum_bad;
    logic        w_addr_bad;
    logic        w_expired;
    logic        w_timer_clear;
    logic        w_timer_en;

    // Timer only runs while a frame is open; any accepted byte restarts it,
    // so a byte landing on the expiry cycle suppresses the timeout.
    assign w_timer_en    = (r_state != ST_IDLE);
    assign w_timer_clear = rx_valid || (r_state == ST_IDLE);

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_timer_clear),
        .enable (w_timer_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_csum_bad   = 1'b0;
        w_addr_bad   = 1'b0;
        if (rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        w_next_state = ST_ADDR;
                    end
                end
                // Mid-frame SYNC bytes are payload, never a restart.
                ST_ADDR: w_next_state = ST_DHI;
                ST_DHI:  w_next_state = ST_DLO;
                ST_DLO:  w_next_state = ST_CSUM;
                ST_CSUM: begin
                    w_next_state = ST_IDLE;
                    if (rx_data != r_csum) begin
                        w_csum_bad = 1'b1;
                    end else if ((r_addr == ADDR_DATA0) || (r_addr == ADDR_DATA1)) begin
                        w_commit = 1'b1;
                    end else begin
                        w_addr_bad = 1'b1;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end else if (w_expired) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= 8'h00;
            r_dhi         <= 8'h00;
            r_dlo         <= 8'h00;
            r_csum        <= 8'h00;
            r_data_0      <= 16'h0000;
            r_data_1      <= 16'h0000;
            r_wr_addr     <= 8'h00;
            r_wr_strobe   <= 1'b0;
            r_csum_err    <= 1'b0;
            r_addr_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wr_strobe   <= w_commit;
            r_csum_err    <= w_csum_bad;
            r_addr_err    <= w_addr_bad;
            r_timeout_err <= w_expired;

            if (rx_valid) begin
                case (r_state)
                    // ADDR seeds the running XOR; SYNC is excluded.
                    ST_ADDR: begin
                        r_addr <= rx_data;
                        r_csum <= rx_data;
                    end
                    ST_DHI: begin
                        r_dhi  <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                    end
                    ST_DLO: begin
                        r_dlo  <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                    end
                    default: ;
                endcase
            end

            if (w_commit) begin
                r_wr_addr <= r_addr;
                if (r_addr == ADDR_DATA0) begin
                    r_data_0 <= {r_dhi, r_dlo};
                end else begin
                    r_data_1 <= {r_dhi, r_dlo};
                end
            end
        end
    end

    assign data_0      = r_data_0;
    assign data_1      = r_data_1;
    assign wr_addr     = r_wr_addr;
    assign wr_strobe   = r_wr_strobe;
    assign csum_err    = r_csum_err;
    assign addr_err    = r_addr_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_serial_reg_writer.sv
module tb_serial_reg_writer;
    import serial_pkg::*;

    localparam int T = 16;
    localparam int K_STROBE = 0;
    localparam int K_CSUM   = 1;
    localparam int K_ADDR   = 2;
    localparam int K_TMO    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] data_0;
    logic [15:0] data_1;
    logic [7:0]  wr_addr;
    logic        wr_strobe;
    logic        csum_err;
    logic        addr_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    serial_reg_writer #(
        .TIMEOUT_CYCLES(T),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .data_0     (data_0),
        .data_1     (data_1),
        .wr_addr    (wr_addr),
        .wr_strobe  (wr_strobe),
        .csum_err   (csum_err),
        .addr_err   (addr_err),
        .timeout_err(timeout_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected responses: kind, cycle it must appear in, register state after it.
    typedef struct {
        int          kind;
        int          at;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  wa;
    } exp_t;
    exp_t q[$];

    // Reference model: bytes of the open frame, time of the last byte,
    // and the register contents the design should hold.
    logic [7:0]  m_frame[$];
    int          m_last;
    logic [15:0] m_d0, m_d1;
    logic [7:0]  m_wa;

    function automatic void push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind; e.at = at; e.d0 = m_d0; e.d1 = m_d1; e.wa = m_wa;
        q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int sc);
        logic [7:0]  a;
        logic [15:0] d;
        m_last = sc;
        if (m_frame.size() == 0) begin
            if (b == 8'hA5) m_frame.push_back(b);
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() == FRAME_LEN) begin
                a = m_frame[1];
                d = {m_frame[2], m_frame[3]};
                if ((m_frame[1] ^ m_frame[2] ^ m_frame[3]) != m_frame[4]) begin
                    push_exp(K_CSUM, sc);
                end else if (a == 8'd0) begin
                    m_d0 = d; m_wa = a; push_exp(K_STROBE, sc);
                end else if (a == 8'd1) begin
                    m_d1 = d; m_wa = a; push_exp(K_STROBE, sc);
                end else begin
                    push_exp(K_ADDR, sc);
                end
                m_frame.delete();
            end
        end
    endfunction

    // One clock of stimulus: a byte (v=1) or an idle cycle.
    task automatic step(input bit v, input logic [7:0] b);
        int sc;
        @(posedge clk); #1;
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        sc = cyc + 1;
        if (v) begin
            model_byte(b, sc);
        end else if (m_frame.size() > 0 && (sc - m_last) >= T) begin
            push_exp(K_TMO, sc);
            m_frame.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                         input logic [7:0] cs);
        send(8'hA5); send(a); send(hi); send(lo); send(cs);
    endtask

    task automatic check_regs(input string tag);
        step(1'b0, 8'h00);
        chk({tag, ".data_0"}, 32'(data_0), 32'(m_d0));
        chk({tag, ".data_1"}, 32'(data_1), 32'(m_d1));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_wa));
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        reset = 1'b1; rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_frame.delete();
        m_d0 = '0; m_d1 = '0; m_wa = '0;
        chk({tag, ".data_0"}, 32'(data_0), 32'h0);
        chk({tag, ".data_1"}, 32'(data_1), 32'h0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'h0);
        chk({tag, ".pulses"}, 32'({wr_strobe, csum_err, addr_err, timeout_err}), 32'h0);
    endtask

    // Monitor: any status pulse must match the oldest expected response.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        if (reset === 1'b0) begin
            n = int'(wr_strobe) + int'(csum_err) + int'(addr_err) + int'(timeout_err);
            if (n > 0) begin
                chk("one_hot_pulse", 32'(n), 32'd1);
                kind = wr_strobe ? K_STROBE : csum_err ? K_CSUM : addr_err ? K_ADDR : K_TMO;
                if (q.size() == 0) begin
                    chk("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", 32'(kind), 32'(e.kind));
                    chk("pulse_cycle", 32'(cyc), 32'(e.at));
                    chk("evt.data_0", 32'(data_0), 32'(e.d0));
                    chk("evt.data_1", 32'(data_1), 32'(e.d1));
                    chk("evt.wr_addr", 32'(wr_addr), 32'(e.wa));
                end
            end else if (q.size() > 0 && cyc > q[0].at) begin
                e = q.pop_front();
                chk("missing_pulse_kind", 32'hFFFF_FFFF, 32'(e.kind));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, hi, lo, cs;
        int         ntrunc;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        m_d0 = '0; m_d1 = '0; m_wa = '0; m_last = 0;
        repeat (2) @(posedge clk);
        do_reset("reset0");

        frame(8'h00, 8'h12, 8'h34, 8'h26);
        check_regs("good_a0");
        frame(8'h01, 8'hBE, 8'hEF, 8'h50);
        check_regs("good_a1");
        frame(8'h00, 8'h12, 8'h34, 8'h27);
        frame(8'h01, 8'h00, 8'h05, 8'h04);
        check_regs("bad_csum_then_good");
        send(8'h33); send(8'h44);
        frame(8'h07, 8'h00, 8'h00, 8'h07);
        check_regs("bad_addr");

        // Abandoned partial frame, then a clean frame.
        send(8'hA5); send(8'h00); send(8'h12);
        idle(T + 4);
        frame(8'h00, 8'hAB, 8'hCD, 8'h66);
        check_regs("after_timeout");

        // Byte lands exactly on the expiry cycle: no error, frame completes.
        send(8'hA5); send(8'h00); send(8'h12);
        idle(T - 1);
        send(8'h34); send(8'h26);
        check_regs("byte_on_expiry");

        // Reset mid-frame; tail bytes must be ignored.
        send(8'hA5); send(8'h01); send(8'hAA);
        do_reset("reset_mid");
        send(8'h55); send(8'h26);
        check_regs("after_reset_tail");
        frame(8'h01, 8'hBE, 8'hEF, 8'h50);
        check_regs("after_reset_frame");

        // Randomized traffic: junk, SYNC-valued payload, bad sums, bad
        // addresses, truncation and gaps around the timeout limit.
        for (int f = 0; f < 200; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) send(8'($urandom));
            case ($urandom_range(0, 5))
                0, 1:    a = 8'h00;
                2, 3:    a = 8'h01;
                4:       a = 8'hA5;
                default: a = 8'($urandom);
            endcase
            hi = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
            lo = 8'($urandom);
            cs = a ^ hi ^ lo;
            if ($urandom_range(0, 4) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
            ntrunc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 5;
            for (int k = 0; k < ntrunc; k++) begin
                case (k)
                    0:       send(8'hA5);
                    1:       send(a);
                    2:       send(hi);
                    3:       send(lo);
                    default: send(cs);
                endcase
                if ($urandom_range(0, 7) == 0) idle($urandom_range(0, T + 2));
            end
            if (ntrunc < 5) idle(T + 1);
        end
        check_regs("random_end");

        idle(T + 5);
        chk("pending_events", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
